// File: rtl/div_pkg.sv
// Shared constants, op encodings and the divider FSM state type.
// Also holds the two's-complement conditional negate used for sign handling.
package div_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the divisor
// magnitude and set the new quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] trial_s;

  // Shifted remainder keeps its carry-out bit: R < |divisor| only bounds 2R+1 to 33 bits.
  always_comb begin
    shifted_s = {rem, quo[XLEN-1]};
    trial_s   = shifted_s - {1'b0, dvsr};
    if (trial_s[XLEN] == 1'b0) begin
      rem_nxt = trial_s[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted_s[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module div_unit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  state_t          state_r;
  logic [4:0]      cnt_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvsr_r;
  logic [XLEN-1:0] result_r;
  logic            is_rem_r;
  logic            q_neg_r;
  logic            r_neg_r;
  logic            busy_r;
  logic            valid_r;

  logic            is_signed_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            div0_s;
  logic            ovf_s;
  logic [XLEN-1:0] special_s;
  logic [XLEN-1:0] rem_nxt_s;
  logic [XLEN-1:0] quo_nxt_s;
  logic [XLEN-1:0] final_s;

  div_step u_step (
    .rem     (rem_r),
    .quo     (quo_r),
    .dvsr    (dvsr_r),
    .rem_nxt (rem_nxt_s),
    .quo_nxt (quo_nxt_s)
  );

  // Operand decode on the request: signs, magnitudes and the two early-out cases.
  always_comb begin
    is_signed_s = ~op[0];
    a_neg_s     = is_signed_s & dividend[XLEN-1];
    b_neg_s     = is_signed_s & divisor[XLEN-1];
    a_mag_s     = cond_neg(dividend, a_neg_s);
    b_mag_s     = cond_neg(divisor, b_neg_s);
    div0_s      = (divisor == 32'd0);
    ovf_s       = is_signed_s && (dividend == INT_MIN) && (divisor == 32'hFFFF_FFFF);
    if (div0_s) begin
      special_s = op[1] ? dividend : DIV0_QUOT;
    end else begin
      special_s = op[1] ? 32'd0 : INT_MIN;
    end
  end

  // Sign-corrected result from the last iteration's output, ready for the DONE entry edge.
  always_comb begin
    if (is_rem_r) begin
      final_s = cond_neg(rem_nxt_s, r_neg_r);
    end else begin
      final_s = cond_neg(quo_nxt_s, q_neg_r);
    end
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 5'd0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      dvsr_r   <= 32'd0;
      result_r <= 32'd0;
      is_rem_r <= 1'b0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (start) begin
            is_rem_r <= op[1];
            q_neg_r  <= a_neg_s ^ b_neg_s;
            r_neg_r  <= a_neg_s;
            busy_r   <= 1'b1;
            if (div0_s || ovf_s) begin
              result_r <= special_s;
              valid_r  <= 1'b1;
              state_r  <= DONE;
            end else begin
              rem_r   <= 32'd0;
              quo_r   <= a_mag_s;
              dvsr_r  <= b_mag_s;
              cnt_r   <= 5'd0;
              state_r <= RUN;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          if (cnt_r == 5'd31) begin
            cnt_r    <= 5'd0;
            result_r <= final_s;
            valid_r  <= 1'b1;
            state_r  <= DONE;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          cnt_r   <= 5'd0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign valid  = valid_r;
  assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at request time and
// matched against each valid pulse; latency, busy window and reset drop are checked too.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  logic [31:0] sb[$];
  int          n_vec;
  int          n_bad;
  int          n_valid;

  div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Independent reference using the language's truncating division.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Result monitor: every valid pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (sb.size() == 0) chk("spurious_valid", {31'd0, valid}, 32'd0);
      else chk("result", result, sb.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after valid.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int inj);
    int cyc;
    int nbusy;
    op = o; dividend = a; divisor = b; start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    cyc = 1;
    nbusy = 0;
    while (!valid && cyc < 40) begin
      if (busy) nbusy++;
      if (cyc == inj) begin
        start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (busy) nbusy++;
    start = 1'b0;
    chk("latency", cyc, lat);
    chk("busy_cycles", nbusy, lat);
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("valid_pulse", {31'd0, valid}, 32'd0);
    chk("result_hold", result, exp);
  endtask

  initial begin
    int vseen;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    n_vec = 0; n_bad = 0; n_valid = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 33, 0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    do_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op(2'b10, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 10);
    do_op(2'b01, 32'd9, 32'd3, 32'd3, 33, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 0);
    do_op(2'b11, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 33, 0);
    do_op(2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 33, 0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) ra = -ra;
      do_op(ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb), 0);
    end

    // Reset in the middle of a RUN drops the operation.
    op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    vseen = n_valid;
    repeat (40) @(negedge clk);
    chk("no_valid_after_rst", n_valid - vseen, 32'd0);

    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the single-cycle add/subtract datapath in the execute stage and produces quotient or remainder by iterative restoring subtraction, one bit per cycle. The execute stage stalls on `busy` and writes back `result` when `valid` pulses.

## Interface
- Parameters: none; width fixed at 32 (`XLEN` constant in package).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  request; accepted only in IDLE
- `op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `dividend`  in  32  rs1 value, sampled on accepted `start`
- `divisor`  in  32  rs2 value, sampled on accepted `start`
- `busy`  out  1  high from the cycle after accept until the cycle after `valid`
- `valid`  out  1  one-cycle pulse: `result` is final
- `result`  out  32  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted `start`

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 captures `op`, operands, sign flags and magnitudes. Signed ops take the absolute value in two's complement; unsigned ops use the raw value.
  - Divisor==0: go to DONE. Quotient=0xFFFFFFFF, remainder=dividend (unmodified).
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: go to DONE. Quotient=0x80000000, remainder=0.
  - Otherwise: go to RUN with counter=0, remainder register R=0, quotient register Q=magnitude of dividend.
- RUN, per cycle:
  - Shift {R,Q} left by 1.
  - Trial T = R − |divisor| at 33 bits.
  - If T is non-negative, R=T[31:0] and Q[0]=1; else Q[0]=0.
  - Counter increments 0..31. After the iteration with counter==31, go to DONE.
- DONE:
  - Sign fix: quotient is negated iff signed op and operand signs differ. Remainder is negated iff signed op and dividend is negative.
  - `result` is loaded on entry to DONE, so it is already valid during DONE.
  - `valid`=1 for exactly one cycle, then return to IDLE.
- `start` while `busy`=1 (RUN or DONE) is ignored. No queueing.
- `op`, `dividend`, `divisor` are don't-care except on the accepting cycle.

## Timing
- Accept at edge E0 (IDLE, `start`=1).
- Normal path:
  - `busy` is high in cycles 1..33 after E0.
  - RUN occupies cycles 1..32.
  - DONE is cycle 33, with `valid`=1 and `result` final.
  - IDLE resumes in cycle 34; a new `start` can be accepted at the end of cycle 34.
- Special path (divide-by-zero, overflow): DONE in cycle 1; `valid` and `busy` high in cycle 1; IDLE in cycle 2.
- Reset (`rst_n`=0 at an edge, any state):
  - State=IDLE, `busy`=0, `valid`=0, `result`=0, counter=0.
  - An in-flight operation is dropped and produces no `valid`.
- Reset takes priority over `start` in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `div_pkg` holds:
  - `XLEN`=32
  - op encodings `OP_DIV`, `OP_DIVU`, `OP_REM`, `OP_REMU`
  - state enum {IDLE, RUN, DONE}
  - constants `DIV0_QUOT`=0xFFFFFFFF, `INT_MIN`=0x80000000
- Sub-module `div_step`: purely combinational single restoring iteration.
  - Inputs: R, Q, |divisor|.
  - Outputs: next R, next Q.
  - It is instantiated once in `div_unit`, which keeps the FSM, counter, sign logic and output registers.

## Test plan
- DIVU 100/7 accepted at E0 → `busy` high for cycles 1..33, `valid` only in cycle 33, `result`=14. Repeat with REMU → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). REM 7/0xFFFFFFFE (−2) → 1.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `valid` in cycle 1 and `busy` low in cycle 2.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each with `valid` in cycle 1.
- REMU 0xFFFFFFFF/0x10 → 0xF. A second `start` (op=DIVU, 9/3) pulsed at cycle 10 is ignored, so `result` is still 0xF. A back-to-back `start` in cycle 34 completes with `result`=3.
- `rst_n`=0 at cycle 12 of a RUN → next cycle `busy`=0, `valid`=0, `result`=0, and no `valid` pulse appears afterwards.
